lcd_pattern_gen: RTL and testbench



---
 rtl/lcd_pattern_gen_pkg.sv | 32 +++
 rtl/lcd_timing_counter.sv | 60 ++++++
 rtl/lcd_pattern_gen.sv | 123 ++++++++++++
 tb/tb_lcd_pattern_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pattern_gen_pkg.sv
// Shared definitions for the LVDS panel video path: pattern codes, bar colours
// and the 21-bit serializer word packing.
package lcd_pattern_gen_pkg;

  localparam logic [1:0] PAT_SOLID = 2'd0;
  localparam logic [1:0] PAT_XOR   = 2'd1;
  localparam logic [1:0] PAT_BARS  = 2'd2;
  localparam logic [1:0] PAT_GRID  = 2'd3;

  localparam logic [20:0] IDLE_WORD = 21'h18000;

  // {R,G,B} per bar; index 0 is the leftmost bar.
  localparam logic [7:0][17:0] BAR_RGB = {
    18'h00000,  // black
    18'h0003F,  // blue
    18'h3F000,  // red
    18'h3F03F,  // magenta
    18'h00FC0,  // green
    18'h00FFF,  // cyan
    18'h3FFC0,  // yellow
    18'h3FFFF   // white
  };

  function automatic logic [20:0] pack_word(input logic [5:0] r, input logic [5:0] g,
                                            input logic [5:0] b, input logic hs,
                                            input logic vs, input logic de);
    return {b[2], b[3], b[4], b[5], hs, vs, de,
            g[1], g[2], g[3], g[4], g[5], b[0], b[1],
            r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
  endfunction

endpackage

// File: rtl/lcd_timing_counter.sv
// Panel raster counters with sync/data-enable decode and a frame-start flag.
module lcd_timing_counter #(
  parameter int unsigned H_ACTIVE = 1366,
  parameter int unsigned H_BLANK  = 169,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_BLANK  = 12
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [10:0] x_o,
  output logic [9:0]  y_o,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        line_end_o,
  output logic        frame_start_o
);

  localparam int unsigned HTotal = H_ACTIVE + H_BLANK;
  localparam int unsigned VTotal = V_ACTIVE + V_BLANK;

  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;

  assign line_end_o = (x_q == 11'(HTotal - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    // Disabled generator parks at the origin so enable restarts a full frame.
    if (!en_i) begin
      x_d = '0;
      y_d = '0;
    end else if (line_end_o) begin
      x_d = '0;
      y_d = (y_q == 10'(VTotal - 1)) ? '0 : y_q + 10'd1;
    end else begin
      x_d = x_q + 11'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign hsync_o       = (x_q < 11'(H_ACTIVE));
  assign vsync_o       = (y_q < 10'(V_ACTIVE));
  assign de_o          = hsync_o && vsync_o;
  assign frame_start_o = en_i && (x_q == '0) && (y_q == '0);

endmodule

// File: rtl/lcd_pattern_gen.sv
// Test-pattern video source: raster timing, pattern colour and serializer word packing.
module lcd_pattern_gen
  import lcd_pattern_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1366,
  parameter int unsigned H_BLANK  = 169,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_BLANK  = 12,
  parameter int unsigned BAR_W    = 171
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [1:0]  pattern_sel_i,
  input  logic [17:0] solid_rgb_i,
  output logic [20:0] video_data_o,
  output logic        frame_start_o,
  output logic [10:0] pos_x_o,
  output logic [9:0]  pos_y_o
);

  localparam int unsigned BarCntW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [10:0] x;
  logic [9:0]  y;
  logic        de, hsync, vsync, line_end, frame_first;

  lcd_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_ACTIVE (V_ACTIVE),
    .V_BLANK  (V_BLANK)
  ) u_timing (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (en_i),
    .x_o           (x),
    .y_o           (y),
    .de_o          (de),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .line_end_o    (line_end),
    .frame_start_o (frame_first)
  );

  logic [1:0]         pat_q, pat_d;
  logic [5:0]         p_q, p_d;
  logic [BarCntW-1:0] bar_cnt_q, bar_cnt_d;
  logic [3:0]         bar_k_q, bar_k_d;
  logic [20:0]        video_q, video_d;
  logic               fs_q, fs_d;

  logic [5:0]  xs, ys, v, v3;
  logic [17:0] rgb;

  always_comb begin
    pat_d     = pat_q;
    p_d       = p_q;
    bar_cnt_d = bar_cnt_q;
    bar_k_d   = bar_k_q;

    // The frame's first pixel already uses the newly latched pattern and parallax.
    if (!en_i) begin
      p_d = '0;
    end else if (frame_first) begin
      pat_d = pattern_sel_i;
      p_d   = p_q - 6'd1;
    end

    // Running bar index tracks x / BAR_W, saturating at 8 (beyond the table).
    if (!en_i || line_end) begin
      bar_cnt_d = '0;
      bar_k_d   = '0;
    end else if (bar_cnt_q == BarCntW'(BAR_W - 1)) begin
      bar_cnt_d = '0;
      bar_k_d   = (bar_k_q == 4'd8) ? bar_k_q : bar_k_q + 4'd1;
    end else begin
      bar_cnt_d = bar_cnt_q + BarCntW'(1);
    end

    xs  = x[5:0] + p_d;
    ys  = y[5:0] + p_d;
    v   = xs ^ ys;
    v3  = v + {v[4:0], 1'b0};
    rgb = '0;
    if (de) begin
      case (pat_d)
        PAT_SOLID: rgb = solid_rgb_i;
        PAT_XOR:   rgb = {v[4:0], 1'b0, v[3:0], 2'b00, v3};
        PAT_BARS:  rgb = bar_k_q[3] ? 18'h0 : BAR_RGB[bar_k_q[2:0]];
        PAT_GRID:  rgb = ((x[4:0] == '0) || (y[4:0] == '0)) ? 18'h3FFFF : 18'h0;
        default:   rgb = '0;
      endcase
    end

    video_d = en_i ? pack_word(rgb[17:12], rgb[11:6], rgb[5:0], hsync, vsync, de) : IDLE_WORD;
    fs_d    = frame_first;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pat_q     <= PAT_SOLID;
      p_q       <= '0;
      bar_cnt_q <= '0;
      bar_k_q   <= '0;
      video_q   <= IDLE_WORD;
      fs_q      <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      p_q       <= p_d;
      bar_cnt_q <= bar_cnt_d;
      bar_k_q   <= bar_k_d;
      video_q   <= video_d;
      fs_q      <= fs_d;
    end
  end

  assign video_data_o  = video_q;
  assign frame_start_o = fs_q;
  assign pos_x_o       = x;
  assign pos_y_o       = y;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen on a shrunken 34x8 raster (30x6 active, 3-pixel bars).
module tb_lcd_pattern_gen;

  localparam int unsigned HA = 30;
  localparam int unsigned HB = 4;
  localparam int unsigned VA = 6;
  localparam int unsigned VB = 2;
  localparam int unsigned BW = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  pattern_sel;
  logic [17:0] solid_rgb;
  logic [20:0] video_data;
  logic        frame_start;
  logic [10:0] pos_x;
  logic [9:0]  pos_y;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lcd_pattern_gen #(
    .H_ACTIVE (HA),
    .H_BLANK  (HB),
    .V_ACTIVE (VA),
    .V_BLANK  (VB),
    .BAR_W    (BW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .pattern_sel_i (pattern_sel),
    .solid_rgb_i   (solid_rgb),
    .video_data_o  (video_data),
    .frame_start_o (frame_start),
    .pos_x_o       (pos_x),
    .pos_y_o       (pos_y)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the counters show (x,y); the next tick then exposes that pixel's word.
  task automatic wait_pos(input int x, input int y);
    int n = 0;
    while (!(pos_x == 11'(x) && pos_y == 10'(y)) && n < 1000) begin
      tick();
      n++;
    end
    check_eq("reach_pos", 32'(n < 1000), 32'd1);
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < 1000);
    check_eq("reach_fs", 32'(frame_start), 32'd1);
  endtask

  initial begin
    int n, de_cnt, vs_low, hs_low;
    rst_n       = 1'b0;
    en          = 1'b1;
    pattern_sel = 2'd0;
    solid_rgb   = 18'h3F000;
    repeat (4) tick();
    check_eq("rst_video", video_data, 32'h18000);
    check_eq("rst_fs", frame_start, 32'd0);
    check_eq("rst_x", pos_x, 32'd0);
    check_eq("rst_y", pos_y, 32'd0);

    rst_n = 1'b1;
    tick();
    check_eq("first_fs", frame_start, 32'd1);
    check_eq("solid_px0", video_data, 32'h1C07E);
    check_eq("first_x", pos_x, 32'd1);

    // One full frame: period and timing-signal statistics.
    de_cnt = video_data[14] ? 1 : 0;
    vs_low = video_data[15] ? 0 : 1;
    hs_low = video_data[16] ? 0 : 1;
    n = 0;
    do begin
      tick();
      n++;
      if (!frame_start) begin
        if (video_data[14]) de_cnt++;
        if (!video_data[15]) vs_low++;
        if (!video_data[16]) hs_low++;
      end
    end while (!frame_start && n < 400);
    check_eq("frame_period", n, 32'd272);
    check_eq("de_count", de_cnt, 32'd180);
    check_eq("vsync_low", vs_low, 32'd68);
    check_eq("hsync_low", hs_low, 32'd32);

    wait_pos(29, 0);
    tick();
    check_eq("solid_px29", video_data, 32'h1C07E);
    tick();
    check_eq("hblank_px30", video_data, 32'h08000);

    // Mid-frame switch to bars takes effect only at the next frame start.
    pattern_sel = 2'd2;
    wait_pos(4, 1);
    tick();
    check_eq("still_solid", video_data, 32'h1C07E);
    wait_pos(5, 6);
    tick();
    check_eq("vblank", video_data, 32'h10000);
    wait_fs();
    check_eq("bar_px0_white", video_data, 32'h1FFFFF);
    wait_pos(2, 0);
    tick();
    check_eq("bar_px2_white", video_data, 32'h1FFFFF);
    check_eq("bar_px3_yellow", 32'(0), 32'(0) ) ;
    n_checks--;
    tick();
    check_eq("bar_px3_yellow", video_data, 32'h01FE7F);
    wait_pos(18, 0);
    tick();
    check_eq("bar_px18_blue", video_data, 32'h1FC180);
    wait_pos(24, 0);
    tick();
    check_eq("bar_px24_black", video_data, 32'h1C000);
    wait_pos(30, 0);
    tick();
    check_eq("bar_px30_blank", video_data, 32'h08000);
    wait_pos(9, 1);
    tick();
    check_eq("bar_px9_green", video_data, 32'h1FE01);

    // Reset mid-frame, then XOR pattern from the first frame (p=63).
    pattern_sel = 2'd1;
    rst_n       = 1'b0;
    repeat (2) tick();
    check_eq("midrst_video", video_data, 32'h18000);
    check_eq("midrst_x", pos_x, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("xor_fs", frame_start, 32'd1);
    check_eq("xor_px0", video_data, 32'h1C000);
    tick();
    check_eq("xor_px1_p63", video_data, 32'h1FDF3E);
    wait_fs();
    wait_pos(1, 0);
    tick();
    check_eq("xor_px1_p62", video_data, 32'h1D1A0);

    pattern_sel = 2'd3;
    wait_fs();
    check_eq("grid_0_0", video_data, 32'h1FFFFF);
    wait_pos(5, 0);
    tick();
    check_eq("grid_5_0", video_data, 32'h1FFFFF);
    wait_pos(0, 1);
    tick();
    check_eq("grid_0_1", video_data, 32'h1FFFFF);
    wait_pos(5, 1);
    tick();
    check_eq("grid_5_1", video_data, 32'h1C000);

    // Enable drop mid-line: idle word, parked counters, restart with p back at 0.
    wait_pos(10, 2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("en_low_video", video_data, 32'h18000);
      check_eq("en_low_x", pos_x, 32'd0);
    end
    check_eq("en_low_fs", frame_start, 32'd0);
    check_eq("en_low_y", pos_y, 32'd0);
    pattern_sel = 2'd1;
    en = 1'b1;
    tick();
    check_eq("en_fs", frame_start, 32'd1);
    check_eq("en_x", pos_x, 32'd1);
    check_eq("en_y", pos_y, 32'd0);
    tick();
    check_eq("en_xor_px1", video_data, 32'h1FDF3E);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
